mul_seq_ctrl: RTL

Sequencer that computes an N x N unsigned product by reusing one 2-bit x 2-bit combinational multiplier (4-bit product) over several clock cycles. It issues one partial product per cycle and accumulates it, shifted, into a 2N-bit accumulator. It gives the lab datapath wide multiplies without building a wide array multiplier. Simple start/busy/done handshake toward the surrounding logic.

---
 rtl/mul_seq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: N x N unsigned multiplier sequencer.
//
// Builds the 2N-bit product from one 2-bit x 2-bit combinational multiplier.
// Each RUN cycle forms one partial product and adds it, shifted into place,
// to a 2N-bit accumulator. A full multiply takes D*D RUN cycles (D = N/2).
//
// Ports:
//   clk    in   system clock; all state changes on the rising edge
//   rst    in   synchronous reset, active-high
//   start  in   request a multiply; only looked at in IDLE
//   a, b   in   N-bit unsigned operands, captured when start is accepted
//   busy   out  high while a multiply is in progress (RUN)
//   done   out  one-cycle pulse when prod holds the new result (DONE)
//   prod   out  2N-bit registered product, held until the next accepted start
module mul_seq_ctrl #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int D  = N / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   ra_q, ra_d;
   logic [N-1:0]   rb_q, rb_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [2*N-1:0] prod_q, prod_d;
   logic [CW-1:0]  i_q, i_d;
   logic [CW-1:0]  j_q, j_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [1:0]     dig_a, dig_b;
   logic [3:0]     pp;
   logic [2*N-1:0] pp_sh;
   logic [2*N-1:0] acc_sum;

   // The single shared 2x2 multiplier; (3*3 = 9) always fits in 4 bits.
   function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
      return {2'b00, x} * {2'b00, y};
   endfunction

   // Digit i of ra times digit j of rb, weighted by 4^(i+j). The add cannot
   // overflow since the full product of two N-bit values fits in 2N bits.
   always_comb begin
      dig_a   = ra_q[2*i_q +: 2];
      dig_b   = rb_q[2*j_q +: 2];
      pp      = mul2x2(dig_a, dig_b);
      pp_sh   = (2*N)'(pp) << (2 * (32'(i_q) + 32'(j_q)));
      acc_sum = acc_q + pp_sh;
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      i_d     = i_q;
      j_d     = j_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               acc_d   = '0;
               prod_d  = '0;   // never expose a stale result while busy
               i_d     = '0;
               j_d     = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            acc_d = acc_sum;
            // j is the inner (fast) digit index, i the outer one.
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) begin
                  i_d     = '0;
                  prod_d  = acc_sum;
                  state_d = S_DONE;
               end else begin
                  i_d = i_q + CW'(1);
               end
            end else begin
               j_d = j_q + CW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags are registered copies of the next-state decode, so they
      // track state_q exactly without any output glue logic.
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         i_q     <= i_d;
         j_q     <= j_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign prod = prod_q;

endmodule
